// File: rtl/riscv_pkg.sv
// ============================================================================
//  riscv_pkg : shared constants and PC-sequencer state encoding
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam logic [31:0]     RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned     INSN_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_TRAP = 2'd3
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
//  pc_target_calc : redirect target adder, JALR bit0 clear, misalign detect
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module pc_target_calc #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic            abs_i,
  output logic [XLEN-1:0] tgt_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] w_sum;

  assign w_sum      = base_i + offset_i;
  // Misalignment is judged on the target after the JALR bit0 clear.
  assign tgt_o      = {w_sum[XLEN-1:1], w_sum[0] & ~abs_i};
  assign misalign_o = |tgt_o[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
//  pc_redirect_unit : fetch PC sequencer with stall-buffered redirects
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
  parameter int unsigned     XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
  parameter int unsigned     INSN_BYTES   = riscv_pkg::INSN_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            pc_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            redir_valid_i,
  input  logic            redir_abs_i,
  input  logic [XLEN-1:0] redir_base_i,
  input  logic [XLEN-1:0] redir_offset_i,
  output logic            flush_o,
  output logic            misalign_err_o
);

  import riscv_pkg::*;

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] w_tgt;
  logic            w_misalign;

  pc_target_calc #(.XLEN(XLEN)) u_tgt (
    .base_i     (redir_base_i),
    .offset_i   (redir_offset_i),
    .abs_i      (redir_abs_i),
    .tgt_o      (w_tgt),
    .misalign_o (w_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redir_valid_i && w_misalign) begin
          state_d = ST_TRAP;
          err_d   = 1'b1;
        end else if (redir_valid_i && !stall_i) begin
          pc_d    = w_tgt;
          flush_d = 1'b1;
        end else if (redir_valid_i) begin
          pend_d  = w_tgt;
          state_d = ST_HOLD;
        end else if (!stall_i && pc_ready_i) begin
          pc_d    = pc_q + XLEN'(INSN_BYTES);
        end
      end
      ST_HOLD: begin
        // A redirect arriving as the stall drops supersedes the buffered one.
        if (redir_valid_i && w_misalign) begin
          state_d = ST_TRAP;
          err_d   = 1'b1;
        end else if (redir_valid_i && stall_i) begin
          pend_d  = w_tgt;
        end else if (redir_valid_i) begin
          pc_d    = w_tgt;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (!stall_i) begin
          pc_d    = pend_q;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  assign pc_o           = pc_q;
  assign pc_valid_o     = (state_q == ST_RUN);
  assign flush_o        = flush_q;
  assign misalign_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
//  tb_pc_redirect_unit : directed + randomized check against a behavioural model
//  Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, pc_ready = 1'b0, redir_valid = 1'b0, redir_abs = 1'b0;
  logic [31:0] redir_base = '0, redir_offset = '0;
  logic        pc_valid, flush, misalign_err;
  logic [31:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: booting / waiting-on-pending / trapped flags
  logic        m_booting, m_waiting, m_trapped, m_flush;
  logic [31:0] m_pc, m_pend;

  pc_redirect_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .pc_ready_i     (pc_ready),
    .pc_valid_o     (pc_valid),
    .pc_o           (pc),
    .redir_valid_i  (redir_valid),
    .redir_abs_i    (redir_abs),
    .redir_base_i   (redir_base),
    .redir_offset_i (redir_offset),
    .flush_o        (flush),
    .misalign_err_o (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"},    pc,                  m_pc);
    chk({tag, "_valid"}, {31'd0, pc_valid},   {31'd0, !m_booting && !m_waiting && !m_trapped});
    chk({tag, "_flush"}, {31'd0, flush},      {31'd0, m_flush});
    chk({tag, "_err"},   {31'd0, misalign_err}, {31'd0, m_trapped});
  endtask

  task automatic model_reset();
    m_booting = 1'b1; m_waiting = 1'b0; m_trapped = 1'b0; m_flush = 1'b0;
    m_pc = 32'h0000_0000; m_pend = '0;
  endtask

  task automatic model_clock();
    logic [31:0] t;
    logic        nf;
    nf = 1'b0;
    t  = redir_base + redir_offset;
    if (redir_abs) t = t & 32'hFFFF_FFFE;
    if (m_trapped) begin
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (redir_valid && (t % 4) != 0) begin
      m_trapped = 1'b1;
    end else if (redir_valid && stall) begin
      m_pend = t; m_waiting = 1'b1;
    end else if (redir_valid) begin
      m_pc = t; nf = 1'b1; m_waiting = 1'b0;
    end else if (m_waiting && !stall) begin
      m_pc = m_pend; nf = 1'b1; m_waiting = 1'b0;
    end else if (!m_waiting && !stall && pc_ready) begin
      m_pc = m_pc + 32'd4;
    end
    m_flush = nf;
  endtask

  task automatic step(input string tag, input logic st, input logic rdy, input logic rv,
                      input logic ab, input logic [31:0] base, input logic [31:0] off);
    stall = st; pc_ready = rdy; redir_valid = rv; redir_abs = ab;
    redir_base = base; redir_offset = off;
    @(posedge clk);
    if (rst) model_reset(); else model_clock();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_model({tag, "_async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model({tag, "_rel"});
  endtask

  initial begin
    logic        st, rdy, rv, ab;
    logic [31:0] base, off;
    model_reset();

    // Boot then sequential fetch
    do_reset("t1");
    for (int i = 0; i < 4; i++) step("t1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_pc_c", pc, 32'h0000_000C);

    // Relative redirect with simultaneous fetch accept
    step("t2a", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100);
    step("t2b", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h20);
    chk("t2_pc", pc, 32'h120);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    step("t2c", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_pc_next", pc, 32'h124);
    chk("t2_flush_next", {31'd0, flush}, 32'd0);

    // Two redirects under stall, newest wins
    step("t3a", 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("t3_valid_a", {31'd0, pc_valid}, 32'd0);
    step("t3b", 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    chk("t3_valid_b", {31'd0, pc_valid}, 32'd0);
    step("t3c", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t3_pc", pc, 32'h300);
    chk("t3_flush", {31'd0, flush}, 32'd1);

    // JALR clears bit0
    step("t4", 1'b0, 1'b0, 1'b1, 1'b1, 32'h1001, 32'h0);
    chk("t4_pc", pc, 32'h1000);
    chk("t4_err", {31'd0, misalign_err}, 32'd0);

    // Misaligned relative target traps and sticks
    step("t5", 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h6);
    chk("t5_err", {31'd0, misalign_err}, 32'd1);
    chk("t5_pc", pc, 32'h1000);
    for (int i = 0; i < 3; i++) step("t5s", 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    chk("t5_sticky", {31'd0, misalign_err}, 32'd1);

    // PC wrap, then reset while holding a pending redirect
    do_reset("t6");
    step("t6a", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t6b", 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'hC);
    step("t6c", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_wrap", pc, 32'h0);
    step("t6d", 1'b1, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0);
    do_reset("t6r");
    step("t6e", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t6f", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_no_pend", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (m_trapped && ($urandom % 6 == 0)) do_reset("rnd");
      st   = ($urandom % 10) < 3;
      rdy  = ($urandom % 10) < 7;
      rv   = ($urandom % 10) < 2;
      ab   = $urandom % 2;
      base = ($urandom % 4 == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC)) : ($urandom & 32'hFFFF_FFFC);
      if (ab) base = base | ($urandom % 2);
      off  = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 16 == 0) off = off | ($urandom % 4);
      step("rnd", st, rdy, rv, ab, base, off);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
